vga_rect_fill: RTL and testbench
================================

// Module: vga_rect_fill
// PURPOSE
//  Avalon-MM master that fills a rectangle of the 640x480 8-bit frame buffer with one palette index.
//  Issues single-pixel writes to the VGA controller's Avalon-MM slave (address bit 19 = 0 selects VRAM).
//  Sits beside the CPU as a simple blitter, offloading clear-screen and box-draw loops.
// PARAMETERS
//  H_RES   640  pixels per line; VRAM address = y*H_RES + x
//  V_RES   480  lines per frame
//  ADDR_W  20   Avalon address width
// PORTS
//  clk              in   1       system clock (same clock as the VGA controller)
//  reset_n          in   1       asynchronous reset, active low
//  start            in   1       one-cycle request; sampled only in IDLE
//  abort            in   1       level; stop after the in-flight write is accepted
//  x0, x1           in   10      inclusive column bounds
//  y0, y1           in   10      inclusive row bounds
//  colour           in   8       palette index written to every pixel
//  busy             out  1       high from accepted start until DONE exits
//  done             out  1       one-cycle pulse at end of a job (normal, empty or aborted)
//  err              out  1       sticky until next start: rectangle empty after clipping, or aborted
//  pix_count        out  19     pixels written in current/last job
//  avm_address      out  ADDR_W  master address; bit 19 always 0
//  avm_chipselect   out  1       equals avm_write
//  avm_write        out  1       write request
//  avm_writedata    out  32      {24'b0, colour}
//  avm_waitrequest  in   1       slave stall
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; busy, done, err, avm_write, avm_chipselect = 0;
//   avm_address, avm_writedata, pix_count = 0. Any in-flight write is dropped.
//  Clipping at start: x1c = min(x1,H_RES-1), y1c = min(y1,V_RES-1); x0,y0 used as given.
//   Empty if x0>x1c or y0>y1c or x0>=H_RES or y0>=V_RES.
//  FSM:
//   IDLE  : start=1 -> latch bounds/colour, clear err and pix_count, busy=1 -> SETUP.
//   SETUP : one cycle; empty -> err=1 -> DONE; else row_base=y0*H_RES (computed by shift-add:
//           y*512+y*128 for H_RES=640, generic shift-add otherwise), cur_x=x0, cur_y=y0 -> WRITE.
//   WRITE : avm_write=1, avm_address=row_base+cur_x. Address/data/write held stable while
//           avm_waitrequest=1. On cycle with waitrequest=0 (accepted): pix_count++, then
//           abort=1 -> err=1 -> DONE; else if cur_x==x1c and cur_y==y1c -> DONE;
//           else if cur_x==x1c: cur_x=x0, cur_y++, row_base+=H_RES; else cur_x++.
//           Next write issued back-to-back (no idle cycle) when more pixels remain.
//   DONE  : avm_write=0, done=1 for exactly one cycle, busy=0 on next cycle -> IDLE.
//  abort is ignored in IDLE/SETUP; never deasserts avm_write while waitrequest=1.
//  start while busy is ignored (no queueing). start and abort together in IDLE: job starts.
//  Throughput: 1 pixel/cycle with waitrequest=0. Latency start->first avm_write = 2 cycles.
//  Full-screen fill (0,0)-(639,479): 307200 writes, final address 307199 (19'h4AFFF).
//  row_base never exceeds (V_RES-1)*H_RES; no wrap into address bit 19.
// TESTING
//  1) start x0=2,x1=4,y0=1,y1=2,colour=8'h5A, waitrequest=0 -> 6 writes, addresses 642,643,644,
//     1282,1283,1284, data 32'h5A, first write 2 cycles after start, done after last, pix_count=6.
//  2) Same job, waitrequest high 3 cycles on each write -> identical address sequence, each
//     address/data held stable while stalled, no duplicates, pix_count=6.
//  3) x0=10,x1=5 (or y0=500) -> no avm_write, err=1, done pulse 2 cycles after start.
//  4) x1=1023,y1=1023 from (638,478) -> clipped to 4 writes: 306558,306559,307198,307199.
//  5) abort raised during 2nd stalled write of a 100-pixel job -> that write completes,
//     no further writes, err=1, pix_count=2, done pulse; start ignored while busy.
//  6) reset_n low mid-job with avm_write=1 -> avm_write/busy drop asynchronously; after release
//     FSM in IDLE, new start runs normally from its own x0,y0.

Source files
------------

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: Avalon-MM blitter that paints a clipped rectangle of the
// 640x480 8-bit frame buffer with a single palette index, one pixel per write.
module vga_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [9:0]        i_x0,
  input  logic [9:0]        i_x1,
  input  logic [9:0]        i_y0,
  input  logic [9:0]        i_y1,
  input  logic [7:0]        i_colour,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [18:0]       o_pix_count,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_chipselect,
  output logic              o_avm_write,
  output logic [31:0]       o_avm_writedata,
  input  logic              i_avm_waitrequest
);

  // Pixel offsets fit in 19 bits; address bit 19 (register space) stays zero.
  localparam int PIX_W = 19;
  localparam logic [9:0]       X_MAX    = 10'(H_RES - 1);
  localparam logic [9:0]       Y_MAX    = 10'(V_RES - 1);
  localparam logic [9:0]       X_LIM    = 10'(H_RES);
  localparam logic [9:0]       Y_LIM    = 10'(V_RES);
  localparam logic [PIX_W-1:0] ROW_STEP = PIX_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [9:0]       r_x0;
  logic [9:0]       r_x1c;
  logic [9:0]       r_y0;
  logic [9:0]       r_y1c;
  logic [7:0]       r_colour;
  logic [9:0]       r_cur_x;
  logic [9:0]       r_cur_y;
  logic [PIX_W-1:0] r_row_base;
  logic             r_err;
  logic [18:0]      r_pix_count;

  logic             w_empty;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last;
  logic [PIX_W-1:0] w_pix_addr;

  // Multiplier-free y*H_RES: the 640 case is y*512 + y*128, anything else
  // sums a shifted copy of y for every set bit of H_RES.
  function automatic logic [PIX_W-1:0] f_row_base(input logic [9:0] y);
    logic [PIX_W-1:0] acc;
    logic [PIX_W-1:0] yw;
    yw  = {9'b0, y};
    acc = '0;
    if (H_RES == 640) begin
      acc = (yw << 9) + (yw << 7);
    end else begin
      for (int i = 0; i < PIX_W; i++) begin
        if (((H_RES >> i) & 1) != 0) begin
          acc = acc + (yw << i);
        end
      end
    end
    return acc;
  endfunction

  assign w_empty   = (r_x0 > r_x1c) || (r_y0 > r_y1c) || (r_x0 >= X_LIM) || (r_y0 >= Y_LIM);
  assign w_accept  = (r_state == S_WRITE) && !i_avm_waitrequest;
  assign w_row_end = (r_cur_x == r_x1c);
  assign w_last    = w_row_end && (r_cur_y == r_y1c);
  assign w_pix_addr = r_row_base + PIX_W'(r_cur_x);

  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_err            = r_err;
  assign o_pix_count      = r_pix_count;
  assign o_avm_write      = (r_state == S_WRITE);
  assign o_avm_chipselect = (r_state == S_WRITE);
  assign o_avm_address    = ADDR_W'(w_pix_addr);
  assign o_avm_writedata  = {24'b0, r_colour};

  // State register; reset drops any in-flight write immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: an accepted write ends the job on abort or on the last pixel.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_SETUP;
      S_SETUP: w_next_state = w_empty ? S_DONE : S_WRITE;
      S_WRITE: if (w_accept && (i_abort || w_last)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Job datapath: latch clipped bounds, walk the raster, count accepted writes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x0        <= '0;
      r_x1c       <= '0;
      r_y0        <= '0;
      r_y1c       <= '0;
      r_colour    <= '0;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_row_base  <= '0;
      r_err       <= 1'b0;
      r_pix_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x0        <= i_x0;
            r_y0        <= i_y0;
            r_x1c       <= (i_x1 > X_MAX) ? X_MAX : i_x1;
            r_y1c       <= (i_y1 > Y_MAX) ? Y_MAX : i_y1;
            r_colour    <= i_colour;
            r_err       <= 1'b0;
            r_pix_count <= '0;
          end
        end
        S_SETUP: begin
          if (w_empty) begin
            r_err <= 1'b1;
          end else begin
            r_row_base <= f_row_base(r_y0);
            r_cur_x    <= r_x0;
            r_cur_y    <= r_y0;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            r_pix_count <= r_pix_count + 19'd1;
            if (i_abort) begin
              r_err <= 1'b1;
            end else if (!w_last) begin
              if (w_row_end) begin
                r_cur_x    <= r_x0;
                r_cur_y    <= r_cur_y + 10'd1;
                r_row_base <= r_row_base + ROW_STEP;
              end else begin
                r_cur_x <= r_cur_x + 10'd1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: directed and randomized rectangle jobs checked against a
// raster-order address list built from the clipping rules with plain loops.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [9:0]  x0, x1, y0, y1;
  logic [7:0]  colour;
  logic        busy, done, err;
  logic [18:0] pixCount;
  logic [19:0] avmAddress;
  logic        avmChipselect, avmWrite;
  logic [31:0] avmWritedata;
  logic        waitrequest;

  int vecCount = 0;
  int errCount = 0;

  always #5 clk = ~clk;

  vga_rect_fill dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_abort(abort),
    .i_x0(x0),
    .i_x1(x1),
    .i_y0(y0),
    .i_y1(y1),
    .i_colour(colour),
    .o_busy(busy),
    .o_done(done),
    .o_err(err),
    .o_pix_count(pixCount),
    .o_avm_address(avmAddress),
    .o_avm_chipselect(avmChipselect),
    .o_avm_write(avmWrite),
    .o_avm_writedata(avmWritedata),
    .i_avm_waitrequest(waitrequest)
  );

  // Single comparison point: counts every check and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: every pixel address of the clipped rectangle in raster order.
  task automatic buildExpected(input int bx0, input int bx1, input int by0, input int by1, output int q[$]);
    int cx1, cy1;
    q = {};
    cx1 = (bx1 > 639) ? 639 : bx1;
    cy1 = (by1 > 479) ? 479 : by1;
    if (bx0 > cx1 || by0 > cy1 || bx0 >= 640 || by0 >= 480) return;
    for (int y = by0; y <= cy1; y++)
      for (int x = bx0; x <= cx1; x++)
        q.push_back(y * 640 + x);
  endtask

  // Runs one job. stallMode: 0 none, 1 three stall cycles per write, 2 random.
  // abortAt>0 raises abort once the abortAt-th write is presented.
  task automatic applyStimulus(input int bx0, input int bx1, input int by0, input int by1,
                               input logic [7:0] col, input int stallMode, input int abortAt,
                               input bit tryRestart);
    int expQ[$];
    int expLen, expCount, accepted, cyc, firstWrite, budget, stallCnt, expAddr;
    bit expErr, doneSeen, stalledPrev, wr;
    logic [19:0] prevAddr;
    logic [31:0] prevData;

    buildExpected(bx0, bx1, by0, by1, expQ);
    expLen = expQ.size();
    if (abortAt > 0 && abortAt <= expLen) begin
      expCount = abortAt;
      expErr   = 1'b1;
      while (expQ.size() > abortAt) void'(expQ.pop_back());
    end else begin
      expCount = expLen;
      expErr   = (expLen == 0);
    end

    @(negedge clk);
    x0 = 10'(bx0); x1 = 10'(bx1); y0 = 10'(by0); y1 = 10'(by1);
    colour = col; start = 1'b1; abort = 1'b0; waitrequest = 1'b0;

    cyc = 0; accepted = 0; firstWrite = -1; doneSeen = 0; stalledPrev = 0;
    stallCnt = 0; budget = expLen * 6 + 20; prevAddr = '0; prevData = '0;
    while (!doneSeen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (stalledPrev) begin
        checkOutput("hold_write", 32'(avmWrite), 32'd1);
        checkOutput("hold_addr", 32'(avmAddress), 32'(prevAddr));
        checkOutput("hold_data", avmWritedata, prevData);
      end
      stalledPrev = 0;
      if (cyc == 1) checkOutput("busy_setup", 32'(busy), 32'd1);
      if (avmWrite && firstWrite < 0) firstWrite = cyc;
      if (done) doneSeen = 1;

      start = (tryRestart && !doneSeen) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (tryRestart) begin
        x0 = 10'($urandom); x1 = 10'($urandom); y0 = 10'($urandom); y1 = 10'($urandom);
        colour = 8'($urandom);
      end
      case (stallMode)
        1:       wr = (stallCnt < 3);
        2:       wr = 1'($urandom_range(0, 1));
        default: wr = 1'b0;
      endcase
      waitrequest = wr;
      if (avmWrite && accepted == abortAt - 1) abort = 1'b1;

      if (avmWrite) begin
        if (!wr) begin
          accepted++;
          stallCnt = 0;
          if (expQ.size() == 0) begin
            checkOutput("extra_write", 32'd1, 32'd0);
          end else begin
            expAddr = expQ.pop_front();
            checkOutput("address", 32'(avmAddress), 32'(expAddr));
          end
          checkOutput("writedata", avmWritedata, {24'b0, col});
          checkOutput("chipselect", 32'(avmChipselect), 32'd1);
        end else begin
          stalledPrev = 1;
          prevAddr = avmAddress;
          prevData = avmWritedata;
          stallCnt++;
        end
      end
    end

    start = 1'b0;
    if (!doneSeen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("writes", 32'(accepted), 32'(expCount));
      if (expLen == 0) checkOutput("empty_done_lat", 32'(cyc), 32'd2);
      else             checkOutput("first_write_lat", 32'(firstWrite), 32'd2);
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("pix_count", 32'(pixCount), 32'(expCount));
      checkOutput("done_write_low", 32'(avmWrite), 32'd0);
    end
    abort = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("idle_write", 32'(avmWrite), 32'd0);
    checkOutput("err_sticky", 32'(err), 32'(expErr));
    checkOutput("pix_hold", 32'(pixCount), 32'(expCount));
  endtask

  // Top-level sequence: reset values, the directed jobs, a mid-job reset, random jobs.
  initial begin
    int rx0, rx1, ry0, ry1, w, h;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; waitrequest = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_write", 32'(avmWrite), 32'd0);
    checkOutput("rst_cs", 32'(avmChipselect), 32'd0);
    checkOutput("rst_addr", 32'(avmAddress), 32'd0);
    checkOutput("rst_data", avmWritedata, 32'd0);
    checkOutput("rst_pix", 32'(pixCount), 32'd0);
    rst_n = 1'b1;

    applyStimulus(2, 4, 1, 2, 8'h5A, 0, 0, 0);
    applyStimulus(2, 4, 1, 2, 8'h5A, 1, 0, 0);
    applyStimulus(10, 5, 0, 0, 8'h33, 0, 0, 0);
    applyStimulus(0, 3, 500, 510, 8'h33, 0, 0, 0);
    applyStimulus(638, 1023, 478, 1023, 8'hC3, 0, 0, 0);
    applyStimulus(0, 99, 10, 10, 8'h11, 1, 2, 1);

    @(negedge clk);
    x0 = 10'd0; x1 = 10'd99; y0 = 10'd3; y1 = 10'd3; colour = 8'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("mid_write", 32'(avmWrite), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_write", 32'(avmWrite), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_addr", 32'(avmAddress), 32'd0);
    checkOutput("async_pix", 32'(pixCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5, 7, 20, 21, 8'hE1, 2, 0, 0);

    for (int n = 0; n < 40; n++) begin
      rx0 = $urandom_range(0, 645);
      w   = $urandom_range(0, 5);
      rx1 = (rx0 + w - 1 < 0) ? 0 : rx0 + w - 1;
      if ($urandom_range(0, 7) == 0) begin rx0 = $urandom_range(634, 645); rx1 = 1023; end
      ry0 = $urandom_range(0, 485);
      h   = $urandom_range(0, 3);
      ry1 = (ry0 + h - 1 < 0) ? 0 : ry0 + h - 1;
      if ($urandom_range(0, 7) == 0) begin ry0 = $urandom_range(476, 485); ry1 = 1023; end
      applyStimulus(rx0, rx1, ry0, ry1, 8'($urandom), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
